// File: rtl/recip_result_uart_fmt_if.sv
// -----------------------------------------------------------------------------
// recip_result_uart_fmt_if
// Bundles the signals of recip_result_uart_fmt: the result strobe from the
// reciprocal counter, the byte-level UART start/busy handshake and the status
// outputs.
//   slave  : the formatter block (consumes results, drives the UART side)
//   master : its environment (result producer + UART transmitter)
// Signals:
//   in_valid / in_n[23:0] / in_coarse[COARSE_WIDTH-1:0] / in_fine[7:0]
//   tx_data[7:0] / tx_start / tx_busy
//   fifo_level[FIFO_AW:0] / drop_cnt[7:0] / frame_done
// -----------------------------------------------------------------------------
interface recip_result_uart_fmt_if #(
  parameter int COARSE_WIDTH = 24,
  parameter int FIFO_AW      = 2
);
  logic                    in_valid;
  logic [23:0]             in_n;
  logic [COARSE_WIDTH-1:0] in_coarse;
  logic [7:0]              in_fine;
  logic [7:0]              tx_data;
  logic                    tx_start;
  logic                    tx_busy;
  logic [FIFO_AW:0]        fifo_level;
  logic [7:0]              drop_cnt;
  logic                    frame_done;

  modport master (
    output in_valid, in_n, in_coarse, in_fine, tx_busy,
    input  tx_data, tx_start, fifo_level, drop_cnt, frame_done
  );

  modport slave (
    input  in_valid, in_n, in_coarse, in_fine, tx_busy,
    output tx_data, tx_start, fifo_level, drop_cnt, frame_done
  );
endinterface

// File: rtl/recip_result_uart_fmt.sv
// -----------------------------------------------------------------------------
// recip_result_uart_fmt
// Output stage of the reciprocal frequency counter (sys domain). Buffers
// result strobes in a small FIFO and prints each one as an ASCII hex line
//   "R=NNNNNN,CCCCCC,FF\r\n"
// through a byte-level UART using its start/busy handshake.
//
// Optional build macro RECIP_FMT_CKSUM_EN: appends ",XX" before CR/LF, where
// XX is the XOR of the first 18 bytes of the line (23-byte frame).
//
// Ports:
//   clk  : sys clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : recip_result_uart_fmt_if.slave
//          in_valid/in_n/in_coarse/in_fine  result strobe
//          tx_data/tx_start/tx_busy          UART byte handshake
//          fifo_level                        entries buffered
//          drop_cnt                          results lost to a full FIFO (sat. 255)
//          frame_done                        pulse after the last byte of a line
// -----------------------------------------------------------------------------
module recip_result_uart_fmt #(
  parameter int COARSE_WIDTH = 24,
  parameter int FIFO_DEPTH   = 4,
  parameter int FIFO_AW      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  recip_result_uart_fmt_if.slave bus
);

`ifdef RECIP_FMT_CKSUM_EN
  localparam logic [4:0] LAST = 5'd22;
`else
  localparam logic [4:0] LAST = 5'd19;
`endif
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_HI, S_WAIT_LO} state_e;

  typedef struct packed {
    logic [23:0] n;
    logic [23:0] coarse;
    logic [7:0]  fine;
  } entry_t;

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  // Nibble 'pos' of a 24-bit field, counted from the most significant end.
  function automatic logic [3:0] nib_at(input logic [23:0] v, input logic [4:0] pos);
    logic [23:0] sh;
    sh = v << {pos, 2'b00};
    return sh[23:20];
  endfunction

  // Coarse count is always printed as 24 bits.
  logic [23:0] coarse24;
  if (COARSE_WIDTH >= 24) begin : g_coarse_trunc
    assign coarse24 = bus.in_coarse[23:0];
  end else begin : g_coarse_ext
    assign coarse24 = {{(24-COARSE_WIDTH){1'b0}}, bus.in_coarse};
  end

  state_e               state_q, state_d;
  logic [4:0]           idx_q, idx_d;
  logic [1:0]           tmo_q, tmo_d;
  entry_t               frame_q, frame_d;
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic [7:0]           drop_q, drop_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 frame_done_q, frame_done_d;
`ifdef RECIP_FMT_CKSUM_EN
  logic [7:0]           cksum_q, cksum_d;
`endif

  entry_t               mem_q [FIFO_DEPTH];
  entry_t               push_entry;
  logic                 full, push, pop, byte_done;
  logic [7:0]           cur_char;

  assign push_entry = '{n: bus.in_n, coarse: coarse24, fine: bus.in_fine};

  // Character at the current frame position, taken from the frozen frame register.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path through the case statements can infer a latch.
    cur_char = 8'h00;
    case (idx_q)
      5'd0:                                   cur_char = 8'h52;   // 'R'
      5'd1:                                   cur_char = 8'h3D;   // '='
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7:     cur_char = hex_char(nib_at(frame_q.n, idx_q - 5'd2));
      5'd8:                                   cur_char = 8'h2C;   // ','
      5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: cur_char = hex_char(nib_at(frame_q.coarse, idx_q - 5'd9));
      5'd15:                                  cur_char = 8'h2C;
      5'd16:                                  cur_char = hex_char(frame_q.fine[7:4]);
      5'd17:                                  cur_char = hex_char(frame_q.fine[3:0]);
`ifdef RECIP_FMT_CKSUM_EN
      5'd18:                                  cur_char = 8'h2C;
      5'd19:                                  cur_char = hex_char(cksum_q[7:4]);
      5'd20:                                  cur_char = hex_char(cksum_q[3:0]);
      5'd21:                                  cur_char = 8'h0D;
      5'd22:                                  cur_char = 8'h0A;
`else
      5'd18:                                  cur_char = 8'h0D;
      5'd19:                                  cur_char = 8'h0A;
`endif
      default:                                cur_char = 8'h00;
    endcase
  end

  // Frame FSM and FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    frame_d      = frame_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    byte_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          frame_d = mem_q[rd_ptr_q];
          idx_d   = 5'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        tx_data_d = cur_char;
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tmo_d      = 2'd0;
          state_d    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        // A UART that never acknowledges must not hang the line: after four
        // cycles without busy the byte is considered sent.
        if (bus.tx_busy) begin
          state_d = S_WAIT_LO;
        end else if (tmo_q == 2'd3) begin
          byte_done = 1'b1;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      S_WAIT_LO: begin
        if (!bus.tx_busy) byte_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_done) begin
      if (idx_q == LAST) begin
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end else begin
        idx_d   = idx_q + 5'd1;
        state_d = S_START;
      end
    end

    // A full FIFO still accepts a push when the FSM pops in the same cycle.
    full     = (level_q == DEPTH_L);
    push     = bus.in_valid && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (FIFO_AW+1)'(1);
      2'b01:   level_d = level_q - (FIFO_AW+1)'(1);
      default: level_d = level_q;
    endcase

    drop_d = drop_q;
    if (bus.in_valid && full && !pop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

`ifdef RECIP_FMT_CKSUM_EN
  // Running XOR of the issued bytes 0..17; restarted for every popped result.
  always_comb begin
    cksum_d = cksum_q;
    if (tx_start_d && idx_q <= 5'd17) cksum_d = cksum_q ^ cur_char;
    if (pop) cksum_d = 8'h00;
  end
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 5'd0;
      tmo_q        <= 2'd0;
      frame_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= 8'h00;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
`ifdef RECIP_FMT_CKSUM_EN
      cksum_q      <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      frame_q      <= frame_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      drop_q       <= drop_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
`ifdef RECIP_FMT_CKSUM_EN
      cksum_q      <= cksum_d;
`endif
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define which
  // entries are valid, so resetting the data would only cost area.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.fifo_level = level_q;
  assign bus.drop_cnt   = drop_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_recip_result_uart_fmt.sv
// -----------------------------------------------------------------------------
// tb_recip_result_uart_fmt
// Self-checking bench for recip_result_uart_fmt. A UART model answers each
// tx_start with 10 busy cycles and records the byte; expected lines are built
// from the result values by string formatting.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_recip_result_uart_fmt;
  localparam int CW         = 24;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int BUSY_CYC   = 10;
`ifdef RECIP_FMT_CKSUM_EN
  localparam int FLEN = 23;
`else
  localparam int FLEN = 20;
`endif
  localparam string CRLF = "\015\012";

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  recip_result_uart_fmt_if #(.COARSE_WIDTH(CW), .FIFO_AW(FIFO_AW)) bus ();

  recip_result_uart_fmt #(
    .COARSE_WIDTH(CW), .FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- UART model and monitors ----------------
  int          busy_cnt   = 0;
  bit          stall_busy = 1'b0;
  bit          mon_en     = 1'b1;
  logic [7:0]  rx_q[$];
  logic [7:0]  last_byte  = 8'h00;
  int          fd_cnt     = 0;
  int          start_viol = 0;
  int          data_viol  = 0;

  assign bus.tx_busy = stall_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    if (bus.tx_start) begin
      rx_q.push_back(bus.tx_data);
      last_byte <= bus.tx_data;
      busy_cnt  <= BUSY_CYC;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (bus.frame_done) fd_cnt <= fd_cnt + 1;
  end

  always @(negedge clk) begin
    if (bus.tx_start && bus.tx_busy) start_viol <= start_viol + 1;
    if (mon_en && busy_cnt != 0 && bus.tx_data !== last_byte) data_viol <= data_viol + 1;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input bit ok, input string got, input string exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, got, exp);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    check(name, got == exp, $sformatf("%0d", got), $sformatf("%0d", exp));
  endtask

  // ---------------- reference model ----------------
  function automatic string hexn(input logic [23:0] v, input int digits);
    string hd = "0123456789ABCDEF";
    string s  = "";
    int    nib;
    for (int d = digits - 1; d >= 0; d--) begin
      nib = int'((v >> (4 * d)) & 24'hF);
      s   = {s, hd.substr(nib, nib)};
    end
    return s;
  endfunction

  function automatic string add_tail(input string body);
`ifdef RECIP_FMT_CKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 0; i < body.len(); i++) x = x ^ body[i];
    return {body, ",", hexn({16'h0, x}, 2), CRLF};
`else
    return {body, CRLF};
`endif
  endfunction

  function automatic string fmt_frame(input logic [23:0] n, input logic [23:0] c, input logic [7:0] f);
    return add_tail({"R=", hexn(n, 6), ",", hexn(c, 6), ",", hexn({16'h0, f}, 2)});
  endfunction

  function automatic string to_hex(input string s);
    string h = "";
    for (int i = 0; i < s.len(); i++) h = {h, $sformatf("%02x", s[i])};
    return h;
  endfunction

  string exp_q[$];
  int    rd_idx = 0;

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic push_result(input logic [23:0] n, input logic [23:0] c, input logic [7:0] f);
    bus.in_valid  = 1'b1;
    bus.in_n      = n;
    bus.in_coarse = c;
    bus.in_fine   = f;
    @(negedge clk);
    bus.in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Compare every queued expected line with the bytes the UART received.
  task automatic drain_frames(input string name);
    int    nfr;
    int    fd0;
    int    budget;
    string exp_s;
    string got_h;
    nfr = exp_q.size();
    fd0 = fd_cnt;
    for (int k = 0; k < nfr; k++) begin
      exp_s  = exp_q.pop_front();
      got_h  = "";
      budget = 0;
      while ((rx_q.size() - rd_idx) < FLEN && budget < 4000) begin
        @(negedge clk);
        budget++;
      end
      if ((rx_q.size() - rd_idx) < FLEN) begin
        check($sformatf("%s frame %0d timeout", name, k), 1'b0,
              $sformatf("%0d bytes", rx_q.size() - rd_idx), $sformatf("%0d bytes", FLEN));
        rd_idx = rx_q.size();
        exp_q.delete();
        return;
      end
      for (int i = 0; i < FLEN; i++) got_h = {got_h, $sformatf("%02x", rx_q[rd_idx + i])};
      rd_idx += FLEN;
      check($sformatf("%s frame %0d", name, k), got_h == to_hex(exp_s), got_h, to_hex(exp_s));
    end
    repeat (30) @(negedge clk);
    check_val({name, " frame_done count"}, fd_cnt - fd0, nfr);
    check_val({name, " extra bytes"}, rx_q.size() - rd_idx, 0);
    check_val({name, " fifo_level"}, int'(bus.fifo_level), 0);
  endtask

  // Six results two cycles apart into an idle block: one pops at once,
  // FIFO_DEPTH are buffered, the rest are dropped.
  task automatic overflow_burst();
    logic [23:0] n, c;
    logic [7:0]  f;
    for (int i = 0; i < 6; i++) begin
      n = 24'($urandom);
      c = 24'($urandom);
      f = 8'($urandom);
      push_result(n, c, f);
      @(negedge clk);
      if (i < FIFO_DEPTH + 1) exp_q.push_back(fmt_frame(n, c, f));
    end
  endtask

  typedef struct {
    logic [23:0] n;
    logic [23:0] c;
    logic [7:0]  f;
    string       body;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] n, c;
    logic [7:0]  f;
    int          sent, burst, base;

    vecs[0] = '{24'h000640, 24'h0186A0, 8'h3C, "R=000640,0186A0,3C"};
    vecs[1] = '{24'hFFFFFF, 24'hFFFFFF, 8'hFF, "R=FFFFFF,FFFFFF,FF"};
    vecs[2] = '{24'h123456, 24'hABCDEF, 8'h09, "R=123456,ABCDEF,09"};
    vecs[3] = '{24'h00000A, 24'h00F000, 8'hA0, "R=00000A,00F000,A0"};

    bus.in_valid  = 1'b0;
    bus.in_n      = '0;
    bus.in_coarse = '0;
    bus.in_fine   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset tx_start",   int'(bus.tx_start), 0);
    check_val("reset tx_data",    int'(bus.tx_data), 0);
    check_val("reset fifo_level", int'(bus.fifo_level), 0);
    check_val("reset drop_cnt",   int'(bus.drop_cnt), 0);
    check_val("reset frame_done", int'(bus.frame_done), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fixed vectors; the first also checks start latency (edge k -> cycle k+2).
    for (int i = 0; i < 4; i++) begin
      push_result(vecs[i].n, vecs[i].c, vecs[i].f);
      exp_q.push_back(add_tail(vecs[i].body));
      if (i == 0) begin
        @(negedge clk);
        check_val("latency no start at k+1", int'(bus.tx_start), 0);
        @(negedge clk);
        check_val("latency start at k+2", int'(bus.tx_start), 1);
        check_val("latency first byte R", int'(bus.tx_data), 8'h52);
      end
      drain_frames($sformatf("vector %0d", i));
    end

    // Overflow: one popped, FIFO_DEPTH buffered, one dropped.
    overflow_burst();
    check_val("overflow drop_cnt", int'(bus.drop_cnt), 6 - (FIFO_DEPTH + 1));
    check_val("overflow fifo_level", int'(bus.fifo_level), FIFO_DEPTH);
    drain_frames("overflow");

    // Saturation: UART stalled busy, 305 back-to-back results -> 300 drops.
    do_reset();
    stall_busy = 1'b1;
    for (int i = 0; i < 305; i++) begin
      n = 24'($urandom);
      c = 24'($urandom);
      f = 8'($urandom);
      push_result(n, c, f);
      if (i < FIFO_DEPTH + 1) exp_q.push_back(fmt_frame(n, c, f));
    end
    check_val("saturate drop_cnt", int'(bus.drop_cnt), (300 > 255) ? 255 : 300);
    check_val("saturate fifo_level", int'(bus.fifo_level), FIFO_DEPTH);
    stall_busy = 1'b0;
    drain_frames("stall drain");

    // Random results in small bursts; pointers wrap, no drops expected.
    sent = 0;
    while (sent < 10) begin
      burst = $urandom_range(1, 4);
      if (burst > 10 - sent) burst = 10 - sent;
      for (int b = 0; b < burst; b++) begin
        n = 24'($urandom);
        c = 24'($urandom);
        f = 8'($urandom);
        push_result(n, c, f);
        exp_q.push_back(fmt_frame(n, c, f));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sent++;
      end
      drain_frames($sformatf("random upto %0d", sent));
    end
    check_val("random drop_cnt held", int'(bus.drop_cnt), 255);

    // Reset in the middle of a frame, at byte idx 7.
    do_reset();
    overflow_burst();
    exp_q.delete();
    base = 0;
    while ((rx_q.size() - rd_idx) < 8 && base < 2000) begin
      @(negedge clk);
      base++;
    end
    check_val("midreset reached idx 7", (rx_q.size() - rd_idx) >= 8 ? 1 : 0, 1);
    check_val("midreset pre fifo_level", int'(bus.fifo_level), FIFO_DEPTH);
    check_val("midreset pre drop_cnt", int'(bus.drop_cnt), 1);
    mon_en = 1'b0;
    do_reset();
    check_val("midreset tx_start", int'(bus.tx_start), 0);
    check_val("midreset tx_data", int'(bus.tx_data), 0);
    check_val("midreset fifo_level", int'(bus.fifo_level), 0);
    check_val("midreset drop_cnt", int'(bus.drop_cnt), 0);
    rd_idx = rx_q.size();
    repeat (200) @(negedge clk);
    check_val("midreset no further bytes", rx_q.size() - rd_idx, 0);
    mon_en = 1'b1;
    push_result(24'hC0FFEE, 24'h000001, 8'h7E);
    exp_q.push_back(add_tail("R=C0FFEE,000001,7E"));
    drain_frames("after reset");

`ifdef RECIP_FMT_CKSUM_EN
    push_result(24'h0, 24'h0, 8'h0);
    exp_q.push_back({"R=000000,000000,00,6F", CRLF});
    drain_frames("checksum zero");
`endif

    check_val("tx_start while busy", start_viol, 0);
    check_val("tx_data unstable while busy", data_viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
